gcd_operand_sequencer: RTL and testbench

GCD_OPERAND_SEQUENCER -- requirements
Module: gcd_operand_sequencer

---
 rtl/gcd_operand_sequencer.sv | 139 +++++++++++++
 tb/tb_gcd_operand_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_operand_sequencer.sv
// Feeds an operand pair serially to a GCD core, waits for completion with a
// timeout, and presents the result downstream on a valid/ready handshake.
module gcd_operand_sequencer #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_op_a,
    input  logic [DATA_W-1:0] i_op_b,
    output logic              o_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_start,
    input  logic              i_done,
    input  logic [DATA_W-1:0] i_result,
    output logic              o_res_valid,
    output logic [DATA_W-1:0] o_res,
    output logic              o_res_err,
    input  logic              i_res_ready,
    output logic [2:0]        o_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; upstream uses i_valid/o_ready, downstream o_res_valid/i_res_ready.

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_WAIT   = 3'd3,
        S_OUT    = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            res_q <= res_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    a_d = i_op_a;
                    b_d = i_op_b;
                    // gcd(0,x) = x, so a zero operand never involves the core
                    if (i_op_a == '0) begin
                        res_d   = i_op_b;
                        err_d   = 1'b0;
                        state_d = S_OUT;
                    end else if (i_op_b == '0) begin
                        res_d   = i_op_a;
                        err_d   = 1'b0;
                        state_d = S_OUT;
                    end else begin
                        state_d = S_LOAD_A;
                    end
                end
            end
            S_LOAD_A: state_d = S_LOAD_B;
            S_LOAD_B: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // done takes priority over a timeout landing in the same cycle
                if (i_done) begin
                    res_d   = i_result;
                    err_d   = 1'b0;
                    state_d = S_OUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        res_d   = '0;
                        err_d   = 1'b1;
                        state_d = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (i_res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_ready     = (state_q == S_IDLE);
        o_start     = (state_q == S_LOAD_A);
        o_res_valid = (state_q == S_OUT);
        o_res       = res_q;
        o_res_err   = err_q;
        o_state     = state_q;
        o_data      = '0;
        case (state_q)
            S_LOAD_A:        o_data = a_q;
            S_LOAD_B, S_WAIT: o_data = b_q;
            default:         o_data = '0;
        endcase
    end

endmodule

// File: tb/tb_gcd_operand_sequencer.sv
// Directed bench for gcd_operand_sequencer: a main instance with the default
// timeout and a second instance with TIMEOUT=16, both driven by the same stimulus.
module tb_gcd_operand_sequencer;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_valid = 1'b0;
    logic [7:0] i_op_a = '0;
    logic [7:0] i_op_b = '0;
    logic       i_done = 1'b0;
    logic [7:0] i_result = '0;
    logic       i_res_ready = 1'b0;

    logic       o_ready, o_start, o_res_valid, o_res_err;
    logic [7:0] o_data, o_res;
    logic [2:0] o_state;
    logic       t_ready, t_start, t_res_valid, t_res_err;
    logic [7:0] t_data, t_res;
    logic [2:0] t_state;

    int checks = 0;
    int failures = 0;

    gcd_operand_sequencer #(.DATA_W(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_op_a(i_op_a), .i_op_b(i_op_b),
        .o_ready(o_ready), .o_data(o_data), .o_start(o_start), .i_done(i_done),
        .i_result(i_result), .o_res_valid(o_res_valid), .o_res(o_res), .o_res_err(o_res_err),
        .i_res_ready(i_res_ready), .o_state(o_state)
    );

    gcd_operand_sequencer #(.DATA_W(8), .TIMEOUT(16)) dut_to (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_op_a(i_op_a), .i_op_b(i_op_b),
        .o_ready(t_ready), .o_data(t_data), .o_start(t_start), .i_done(i_done),
        .i_result(i_result), .o_res_valid(t_res_valid), .o_res(t_res), .o_res_err(t_res_err),
        .i_res_ready(i_res_ready), .o_state(t_state)
    );

    // clock / reset
    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] result;
        logic [7:0] exp_res;
        int         delay;
        int         hold;
        bit         zero;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic handoff();
        i_res_ready = 1'b1;
        tick();
        i_res_ready = 1'b0;
    endtask

    task automatic run_pair(input vec_t v);
        int         cyc;
        bit         bus_bad;
        bit         ok;
        logic [7:0] held;
        chk("idle_ready", o_ready, 1);
        i_valid = 1'b1;
        i_op_a  = v.a;
        i_op_b  = v.b;
        tick();
        i_valid = 1'b0;
        if (v.zero) begin
            chk("zero_valid_c1", o_res_valid, 1);
            chk("zero_no_start", o_start, 0);
        end else begin
            chk("load_a_start", o_start, 1);
            chk("load_a_data", o_data, v.a);
            tick();
            chk("load_b_start", o_start, 0);
            chk("load_b_data", o_data, v.b);
            tick();
            chk("wait_state", o_state, 3);
            cyc = 0;
            bus_bad = 0;
            while (!o_res_valid && cyc < 2000) begin
                if (o_start || o_data !== v.b) bus_bad = 1;
                if (cyc == v.delay) begin
                    i_done   = 1'b1;
                    i_result = v.result;
                end
                tick();
                i_done   = 1'b0;
                i_result = '0;
                cyc++;
            end
            chk("wait_bus_stable", bus_bad, 0);
            chk("done_latency", cyc, v.delay + 1);
        end
        chk("res", o_res, v.exp_res);
        chk("res_err", o_res_err, 0);
        chk("res_valid", o_res_valid, 1);
        ok = 1;
        held = o_res;
        for (int k = 0; k < v.hold; k++) begin
            tick();
            if (!o_res_valid || o_res !== held || o_ready || o_state !== 3'd4) ok = 0;
        end
        if (v.hold > 0) chk("hold_stable", ok, 1);
        handoff();
        chk("back_to_idle", o_state, 0);
        chk("valid_low", o_res_valid, 0);
    endtask

    initial begin
        logic [7:0] exp_q[$];
        logic [7:0] bb_a[4];
        logic [7:0] bb_b[4];
        logic [7:0] bb_r[4];
        int  cyc, got, starts, k;
        bit  acc, ok;

        vecs[0] = '{8'd48,  8'd18,  8'd6,   8'd6,   18, 5, 1'b0};
        vecs[1] = '{8'd0,   8'd35,  8'd0,   8'd35,  0,  0, 1'b1};
        vecs[2] = '{8'd35,  8'd0,   8'd0,   8'd35,  0,  0, 1'b1};
        vecs[3] = '{8'd0,   8'd0,   8'd0,   8'd0,   0,  0, 1'b1};
        vecs[4] = '{8'd100, 8'd75,  8'd25,  8'd25,  1,  0, 1'b0};
        vecs[5] = '{8'd255, 8'd255, 8'd255, 8'd255, 0,  2, 1'b0};
        vecs[6] = '{8'd13,  8'd1,   8'd1,   8'd1,   5,  0, 1'b0};

        // reset values while reset is held
        #1;
        tick();
        chk("rst_ready", o_ready, 1);
        chk("rst_start", o_start, 0);
        chk("rst_data", o_data, 0);
        chk("rst_valid", o_res_valid, 0);
        chk("rst_res", o_res, 0);
        chk("rst_err", o_res_err, 0);
        chk("rst_state", o_state, 0);
        i_rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) run_pair(vecs[i]);

        // done and timeout in the same cycle on the TIMEOUT=16 instance
        i_valid = 1'b1; i_op_a = 8'd9; i_op_b = 8'd6;
        tick();
        i_valid = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 15; i++) tick();
        chk("tie_still_wait", t_state, 3);
        i_done = 1'b1; i_result = 8'd3;
        tick();
        i_done = 1'b0; i_result = '0;
        chk("tie_valid", t_res_valid, 1);
        chk("tie_res", t_res, 3);
        chk("tie_err", t_res_err, 0);
        handoff();

        // timeout with i_done held low, then a late i_done
        i_valid = 1'b1; i_op_a = 8'd7; i_op_b = 8'd5;
        tick();
        i_valid = 1'b0;
        cyc = 1;
        while (!t_res_valid && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("timeout_cycle", cyc, 19);
        chk("timeout_res", t_res, 0);
        chk("timeout_err", t_res_err, 1);
        chk("main_still_wait", o_state, 3);
        i_done = 1'b1; i_result = 8'd99;
        tick();
        tick();
        i_done = 1'b0; i_result = '0;
        chk("late_done_res", t_res, 0);
        chk("late_done_err", t_res_err, 1);
        chk("late_done_valid", t_res_valid, 1);
        chk("main_took_done", o_res, 99);
        handoff();

        // reset pulsed in WAIT, then a stale done
        i_valid = 1'b1; i_op_a = 8'd20; i_op_b = 8'd10;
        tick();
        i_valid = 1'b0;
        tick();
        tick();
        chk("pre_rst_wait", o_state, 3);
        i_rst = 1'b1;
        #2;
        chk("async_rst_state", o_state, 0);
        chk("async_rst_data", o_data, 0);
        tick();
        i_rst = 1'b0;
        i_done = 1'b1; i_result = 8'd77;
        ok = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (o_state !== 3'd0 || o_res_valid) ok = 0;
        end
        i_done = 1'b0; i_result = '0;
        chk("stale_done_ignored", ok, 1);
        run_pair('{8'd12, 8'd8, 8'd4, 8'd4, 2, 0, 1'b0});

        // back-to-back pairs with i_valid held high and the core answering at once
        bb_a = '{8'd6, 8'd9, 8'd0, 8'd10};
        bb_b = '{8'd4, 8'd3, 8'd7, 8'd15};
        bb_r = '{8'd2, 8'd3, 8'd7, 8'd5};
        k = 0; got = 0; starts = 0; cyc = 0;
        i_valid = 1'b1; i_res_ready = 1'b1; i_done = 1'b1;
        i_op_a = bb_a[0]; i_op_b = bb_b[0];
        while (got < 4 && cyc < 300) begin
            acc = o_ready && i_valid;
            if (acc) begin
                exp_q.push_back(bb_r[k]);
                i_result = bb_r[k];
            end
            if (o_start) starts++;
            if (o_res_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL bb_extra actual=%0d expected=none", o_res);
                end else begin
                    chk("bb_res", o_res, exp_q.pop_front());
                end
                got++;
            end
            tick();
            cyc++;
            if (acc) begin
                k++;
                if (k < 4) begin
                    i_op_a = bb_a[k];
                    i_op_b = bb_b[k];
                end else begin
                    i_valid = 1'b0;
                end
            end
        end
        i_valid = 1'b0; i_res_ready = 1'b0; i_done = 1'b0;
        chk("bb_count", got, 4);
        chk("bb_starts", starts, 3);
        chk("bb_queue_empty", exp_q.size(), 0);
        tick();
        chk("bb_idle", o_state, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
